adder_arb: RTL and testbench
============================

ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port req  input  NREQ  per-requester add request; held high with operands stable until done.
REQ-005 Port op_a  input  16*NREQ  operand A, requester i at bits [16i+15:16i].
REQ-006 Port op_b  input  16*NREQ  operand B, same packing as op_a.
REQ-007 Port gnt  output  NREQ  one-hot grant, registered; all-zero when idle.
REQ-008 Port done  output  NREQ  one-hot, one-cycle pulse; result valid for flagged requester.
REQ-009 Port sum  output  16  registered result of the granted add.
REQ-010 Port co  output  1  registered carry-out of the granted add.
REQ-011 Port busy  output  1  high in ADD and DONE states.

Function
REQ-012 Block SHALL share one 16-bit adder among NREQ requesters, one add at a time.
REQ-013 FSM states SHALL be IDLE, ADD and DONE only.
REQ-014 IDLE: if any req bit is high, the block SHALL select a winner round-robin, register its operands and one-hot gnt, and enter ADD; otherwise stay in IDLE.
REQ-015 Round-robin SHALL search from index ptr upward, wrapping NREQ-1 to 0; first asserted req wins.
REQ-016 On each grant, ptr SHALL become (winner+1) mod NREQ.
REQ-017 ADD: adder output from the captured operands SHALL be registered into sum/co, then the FSM enters DONE; ADD lasts exactly one cycle.
REQ-018 DONE: done[winner] SHALL be high for exactly one cycle, gnt SHALL clear on exit, and the FSM returns to IDLE.
REQ-019 Latency: req sampled high at edge N -> gnt high from N+1 -> done pulse and valid sum/co in cycle N+2..N+3 (DONE state); the next grant is at the earliest edge N+3.
REQ-020 sum SHALL equal (A+B) mod 2^16; co SHALL equal bit 16 of A+B; carry-in is always 0.
REQ-021 sum/co SHALL hold their value until the next ADD completes.
REQ-022 Operands SHALL be captured at grant; later changes to op_a/op_b or deassertion of req SHALL not affect the operation in flight, and done still pulses.
REQ-023 A requester still asserting req in its DONE cycle SHALL be treated as a new request, subject to round-robin fairness.
REQ-024 Requests arriving while busy SHALL wait; none are lost as long as req stays high.
REQ-025 With all NREQ requesting continuously, each SHALL be granted once per NREQ grants.

Reset
REQ-026 While rst_n is low at a clock edge, state SHALL go to IDLE, ptr to 0, and gnt, done, sum, co and busy to 0.
REQ-027 Reset asserted during ADD or DONE SHALL abort the operation with no done pulse.
REQ-028 The first grant after reset SHALL go to the lowest-index asserted req.

Structure
REQ-029 The state encoding (IDLE/ADD/DONE) and the operand width constant (16) SHALL live in a shared package.
REQ-030 The adder SHALL be a single fulladder16 sub-module instance fed by the captured operand registers; the arbitration logic stays in adder_arb.

Verification
REQ-031 Single request: req=0001, A=0x1234, B=0x0001 -> gnt=0001 next cycle, done=0001 two cycles later, sum=0x1235, co=0.
REQ-032 Wrap-around: req[2], A=0xFFFF, B=0x0001 -> done=0100, sum=0x0000, co=1.
REQ-033 Fairness: req=1111 held constantly from reset -> grant order 0,1,2,3,0, with each done 3 cycles apart.
REQ-034 Operand change: drop req[1] and set A=0 the cycle after gnt=0010 (original A=5, B=7) -> done=0010, sum=0x000C.
REQ-035 Reset mid-operation: rst_n low during ADD -> no done pulse; gnt, sum, co=0; the next request is granted from ptr=0.
REQ-036 Back-to-back: req[3] rises while req[0] is being served -> gnt=1000 on the first IDLE edge after done=0001.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the shared-adder arbiter.
//   DATA_W    : operand / result width
//   state_e   : arbiter FSM encoding
//   operand_t : operand pair captured at grant
package adder_arb_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operand_t;

endpackage : adder_arb_pkg

// File: rtl/adder_arb_if.sv
// Request/response bundle between NREQ requesters and the shared adder.
//   req        : per-requester add request
//   op_a, op_b : packed operands, requester i at [DATA_W*i +: DATA_W]
//   gnt, done  : one-hot grant / one-cycle completion pulse
//   sum, co    : result of the last completed add
//   busy       : an add is in flight
interface adder_arb_if
  import adder_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]        req;
  logic [DATA_W*NREQ-1:0] op_a;
  logic [DATA_W*NREQ-1:0] op_b;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      sum;
  logic                   co;
  logic                   busy;

  modport master (
    output req, op_a, op_b,
    input  gnt, done, sum, co, busy
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, done, sum, co, busy
  );

endinterface : adder_arb_if

// File: rtl/adder_arb_fulladder16.sv
// Combinational DATA_W-bit adder with carry-in and carry-out.
//   a_i, b_i, ci_i : addends and carry-in
//   sum_c_o, co_c_o: unregistered sum and carry-out
module fulladder16
  import adder_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              ci_i,
  output logic [DATA_W-1:0] sum_c_o,
  output logic              co_c_o
);

  logic [DATA_W:0] full_c;

  assign full_c  = (DATA_W+1)'(a_i) + (DATA_W+1)'(b_i) + (DATA_W+1)'(ci_i);
  assign sum_c_o = full_c[DATA_W-1:0];
  assign co_c_o  = full_c[DATA_W];

endmodule : fulladder16

// File: rtl/adder_arb.sv
// Round-robin arbiter sharing one adder among NREQ requesters.
// One add at a time: IDLE (arbitrate, capture operands) -> ADD (register
// result) -> DONE (pulse done) -> IDLE.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : adder_arb_if slave modport (req/op_a/op_b in, gnt/done/sum/co/busy out)
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_arb_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              co_q, co_d;
  logic              busy_q, busy_d;
  operand_t          opnd_q, opnd_d;

  logic              found_c;
  logic [PTR_W-1:0]  winner_c;
  operand_t          sel_opnd_c;
  logic [DATA_W-1:0] add_sum_c;
  logic              add_co_c;

  // Round-robin search starting at ptr, wrapping at NREQ-1.
  always_comb begin
    int unsigned idx;
    found_c  = 1'b0;
    winner_c = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && bus.req[PTR_W'(idx)]) begin
        found_c  = 1'b1;
        winner_c = PTR_W'(idx);
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    sel_opnd_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner_c == PTR_W'(i)) begin
        sel_opnd_c.a = bus.op_a[DATA_W*i +: DATA_W];
        sel_opnd_c.b = bus.op_b[DATA_W*i +: DATA_W];
      end
    end
  end

  // Shared adder works only from the captured operands.
  fulladder16 u_add (
    .a_i     (opnd_q.a),
    .b_i     (opnd_q.b),
    .ci_i    (1'b0),
    .sum_c_o (add_sum_c),
    .co_c_o  (add_co_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      opnd_q  <= opnd_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    sum_d   = sum_q;
    co_d    = co_q;
    busy_d  = busy_q;
    opnd_d  = opnd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          gnt_d   = NREQ'(1) << winner_c;
          opnd_d  = sel_opnd_c;
          ptr_d   = (winner_c == PTR_W'(NREQ-1)) ? '0 : winner_c + PTR_W'(1);
          busy_d  = 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d   = add_sum_c;
        co_d    = add_co_c;
        done_d  = gnt_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
  assign bus.busy = busy_q;

endmodule : adder_arb

// File: tb/tb_adder_arb.sv
// Directed self-checking bench for adder_arb (NREQ = 4).
module tb_adder_arb;
  import adder_arb_pkg::*;

  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  adder_arb_if #(.NREQ(NREQ)) bus ();

  adder_arb #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        co;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int unsigned i, input logic [15:0] a, input logic [15:0] b);
    bus.op_a[16*i +: 16] = a;
    bus.op_b[16*i +: 16] = b;
  endtask

  logic [15:0] fair_sum[4];

  initial begin
    vecs[0] = '{0, 16'h1234, 16'h0001, 16'h1235, 1'b0};
    vecs[1] = '{2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[3] = '{3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    vecs[4] = '{0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[5] = '{2, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{1, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0};
    vecs[7] = '{3, 16'hF0F0, 16'h0F10, 16'h0000, 1'b1};
    fair_sum[0] = 16'h1212;
    fair_sum[1] = 16'h2323;
    fair_sum[2] = 16'h3434;
    fair_sum[3] = 16'h4545;

    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    chk("reset_gnt",  32'(bus.gnt),  32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_sum",  32'(bus.sum),  32'h0);
    chk("reset_co",   32'(bus.co),   32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_gnt", 32'(bus.gnt), 32'h0);

    // Single-request vectors: grant, result, return to idle.
    for (int v = 0; v < 8; v++) begin
      set_op(vecs[v].idx, vecs[v].a, vecs[v].b);
      bus.req = 4'(1 << vecs[v].idx);
      tick();
      chk("vec_gnt",  32'(bus.gnt),  32'(1 << vecs[v].idx));
      chk("vec_busy", 32'(bus.busy), 32'h1);
      bus.req = '0;
      tick();
      chk("vec_done", 32'(bus.done), 32'(1 << vecs[v].idx));
      chk("vec_sum",  32'(bus.sum),  32'(vecs[v].sum));
      chk("vec_co",   32'(bus.co),   32'(vecs[v].co));
      tick();
      chk("vec_done_clr", 32'(bus.done), 32'h0);
      chk("vec_gnt_clr",  32'(bus.gnt),  32'h0);
      chk("vec_busy_clr", 32'(bus.busy), 32'h0);
      chk("vec_sum_hold", 32'(bus.sum),  32'(vecs[v].sum));
    end

    // Fairness: all four requesting continuously from reset.
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h1111 * (i + 1)), 16'h0101);
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("fair_gnt", 32'(bus.gnt), 32'(1 << (n % 4)));
      tick();
      chk("fair_done", 32'(bus.done), 32'(1 << (n % 4)));
      chk("fair_sum",  32'(bus.sum),  32'(fair_sum[n % 4]));
      tick();
      chk("fair_gap", 32'(bus.done), 32'h0);
    end
    bus.req = '0;

    // Operand change and req drop after grant (ptr is now 1).
    set_op(1, 16'h0005, 16'h0007);
    bus.req = 4'b0010;
    tick();
    chk("opchg_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    set_op(1, 16'h0000, 16'h0007);
    tick();
    chk("opchg_done", 32'(bus.done), 32'h2);
    chk("opchg_sum",  32'(bus.sum),  32'h000C);
    tick();

    // Reset during ADD aborts, ptr returns to 0.
    set_op(0, 16'h00FF, 16'h0001);
    set_op(3, 16'h0001, 16'h0001);
    bus.req = 4'b0001;
    tick();
    chk("rst_pre_gnt", 32'(bus.gnt), 32'h1);
    rst_n   = 1'b0;
    bus.req = 4'b1001;
    tick();
    chk("rst_mid_done", 32'(bus.done), 32'h0);
    chk("rst_mid_gnt",  32'(bus.gnt),  32'h0);
    chk("rst_mid_sum",  32'(bus.sum),  32'h0);
    chk("rst_mid_co",   32'(bus.co),   32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_post_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    chk("rst_post_done", 32'(bus.done), 32'h1);
    chk("rst_post_sum",  32'(bus.sum),  32'h0100);
    tick();

    // Back-to-back: req[3] arrives while requester 0 is served (ptr is 1).
    set_op(0, 16'h0002, 16'h0003);
    set_op(3, 16'h1000, 16'h0234);
    bus.req = 4'b0001;
    tick();
    chk("b2b_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b1001;
    tick();
    chk("b2b_done0", 32'(bus.done), 32'h1);
    chk("b2b_sum0",  32'(bus.sum),  32'h0005);
    tick();
    chk("b2b_gap_gnt",  32'(bus.gnt),  32'h0);
    chk("b2b_gap_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("b2b_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    tick();
    chk("b2b_done3", 32'(bus.done), 32'h8);
    chk("b2b_sum3",  32'(bus.sum),  32'h1234);
    tick();
    tick();
    chk("b2b_idle_gnt", 32'(bus.gnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adder_arb
